instruction_decode_controller: RTL and testbench

Fetches 32-bit instructions from a synchronous instruction ROM and decodes them. Dispatches ADD/ADDI operations to the addition operation controller over its start/busy/done handshake and owns the program counter. Sits directly upstream of the addition operation controller, in the same clock and reset domain.

---
 rtl/isa_pkg.sv | 41 ++++
 rtl/instr_field_decode.sv | 41 ++++
 rtl/instruction_decode_controller.sv | 169 ++++++++++++++++
 tb/tb_instruction_decode_controller.sv | 352 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/isa_pkg.sv
// Shared ISA definitions for the instruction decode controller: opcodes, field
// positions, operation types and the decoder FSM state encoding.
package isa_pkg;

  localparam logic [5:0] OpNop  = 6'h00;
  localparam logic [5:0] OpAdd  = 6'h01;
  localparam logic [5:0] OpAddi = 6'h02;
  localparam logic [5:0] OpHalt = 6'h3F;

  localparam int unsigned OpcodeMsb = 31;
  localparam int unsigned OpcodeLsb = 26;
  localparam int unsigned RdMsb     = 25;
  localparam int unsigned RdLsb     = 21;
  localparam int unsigned Rs1Msb    = 20;
  localparam int unsigned Rs1Lsb    = 16;
  localparam int unsigned Rs2Msb    = 15;
  localparam int unsigned Rs2Lsb    = 11;
  localparam int unsigned ImmMsb    = 15;
  localparam int unsigned ImmLsb    = 0;

  localparam logic [1:0] OpTypeR = 2'd0;
  localparam logic [1:0] OpTypeI = 2'd1;

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StDecode,
    StIssue,
    StWaitAccept,
    StWaitDone,
    StHalted
  } dec_state_e;

  typedef enum logic [1:0] {
    ClsNop,
    ClsAdd,
    ClsHalt,
    ClsIllegal
  } op_class_e;

endpackage

// File: rtl/instr_field_decode.sv
// Combinational split of an instruction word into opcode class and the operand
// fields handed to the add controller.
module instr_field_decode
  import isa_pkg::*;
(
  input  logic [31:0] instr,
  output op_class_e   op_class,
  output logic [1:0]  op_type,
  output logic [4:0]  rd,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  output logic [31:0] imm
);

  logic [5:0] opcode;

  assign opcode = instr[OpcodeMsb:OpcodeLsb];
  assign rd     = instr[RdMsb:RdLsb];
  assign rs1    = instr[Rs1Msb:Rs1Lsb];

  always_comb begin
    op_class = ClsIllegal;
    op_type  = OpTypeR;
    rs2      = instr[Rs2Msb:Rs2Lsb];
    imm      = '0;
    case (opcode)
      OpNop:  op_class = ClsNop;
      OpAdd:  op_class = ClsAdd;
      OpAddi: begin
        // rs2 bits overlap imm16, so they are forced to zero for ADDI
        op_class = ClsAdd;
        op_type  = OpTypeI;
        rs2      = '0;
        imm      = {instr[ImmMsb:ImmLsb], 16'h0000};
      end
      OpHalt: op_class = ClsHalt;
      default: op_class = ClsIllegal;
    endcase
  end

endmodule

// File: rtl/instruction_decode_controller.sv
// Fetches instructions from a synchronous ROM, decodes them and dispatches ADD/ADDI
// to the add controller over a start/busy/done handshake. Owns the PC.
module instruction_decode_controller
  import isa_pkg::*;
#(
  parameter logic [4:0]  RESET_PC       = 5'd0,
  parameter int unsigned ACCEPT_TIMEOUT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        run,
  output logic [4:0]  imem_addr,
  input  logic [31:0] imem_data,
  output logic        add_start,
  output logic [4:0]  add_pc,
  output logic [1:0]  add_operation_type,
  output logic [4:0]  add_source_1_address,
  output logic [4:0]  add_source_2_address,
  output logic [4:0]  add_destination_address,
  output logic [31:0] add_source_immediate_value,
  input  logic        add_busy,
  input  logic        add_done,
  input  logic [4:0]  add_next_pc,
  output logic        halted,
  output logic        illegal_instr,
  output logic        accept_timeout,
  output logic [15:0] retired_count
);

  localparam int unsigned CntW = $clog2(ACCEPT_TIMEOUT + 1);

  dec_state_e      state_q, state_d;
  logic [4:0]      pc_q, pc_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [15:0]     retired_q, retired_d;
  logic            halted_q, halted_d;
  logic            illegal_q, illegal_d;
  logic            timeout_q, timeout_d;
  logic            load_fields;

  logic [4:0]  add_pc_q, rs1_q, rs2_q, rd_q;
  logic [1:0]  op_type_q;
  logic [31:0] imm_q;

  op_class_e   dec_class;
  logic [1:0]  dec_op_type;
  logic [4:0]  dec_rd, dec_rs1, dec_rs2;
  logic [31:0] dec_imm;

  instr_field_decode u_field_decode (
    .instr    (imem_data),
    .op_class (dec_class),
    .op_type  (dec_op_type),
    .rd       (dec_rd),
    .rs1      (dec_rs1),
    .rs2      (dec_rs2),
    .imm      (dec_imm)
  );

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    cnt_d       = cnt_q;
    retired_d   = retired_q;
    halted_d    = halted_q;
    illegal_d   = illegal_q;
    timeout_d   = timeout_q;
    load_fields = 1'b0;
    unique case (state_q)
      StIdle:  if (run) state_d = StFetch;
      StFetch: state_d = StDecode;
      StDecode: begin
        case (dec_class)
          ClsNop: begin
            pc_d      = pc_q + 5'd1;
            retired_d = retired_q + 16'd1;
            state_d   = run ? StFetch : StIdle;
          end
          ClsAdd: begin
            load_fields = 1'b1;
            state_d     = StIssue;
          end
          ClsHalt: begin
            halted_d = 1'b1;
            state_d  = StHalted;
          end
          default: begin
            illegal_d = 1'b1;
            halted_d  = 1'b1;
            state_d   = StHalted;
          end
        endcase
      end
      StIssue: begin
        cnt_d   = '0;
        state_d = StWaitAccept;
      end
      StWaitAccept: begin
        // done is deliberately ignored here: it may still be high from the last op
        if (add_busy) begin
          state_d = StWaitDone;
        end else if (cnt_q == CntW'(ACCEPT_TIMEOUT - 1)) begin
          timeout_d = 1'b1;
          halted_d  = 1'b1;
          state_d   = StHalted;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StWaitDone: begin
        if (add_done && !add_busy) begin
          pc_d      = add_next_pc;
          retired_d = retired_q + 16'd1;
          state_d   = run ? StFetch : StIdle;
        end
      end
      StHalted: state_d = StHalted;
      default:  state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      pc_q      <= RESET_PC;
      cnt_q     <= '0;
      retired_q <= '0;
      halted_q  <= 1'b0;
      illegal_q <= 1'b0;
      timeout_q <= 1'b0;
      add_pc_q  <= '0;
      op_type_q <= '0;
      rs1_q     <= '0;
      rs2_q     <= '0;
      rd_q      <= '0;
      imm_q     <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      cnt_q     <= cnt_d;
      retired_q <= retired_d;
      halted_q  <= halted_d;
      illegal_q <= illegal_d;
      timeout_q <= timeout_d;
      if (load_fields) begin
        add_pc_q  <= pc_q;
        op_type_q <= dec_op_type;
        rs1_q     <= dec_rs1;
        rs2_q     <= dec_rs2;
        rd_q      <= dec_rd;
        imm_q     <= dec_imm;
      end
    end
  end

  assign imem_addr                  = pc_q;
  assign add_start                  = (state_q == StIssue);
  assign add_pc                     = add_pc_q;
  assign add_operation_type         = op_type_q;
  assign add_source_1_address       = rs1_q;
  assign add_source_2_address       = rs2_q;
  assign add_destination_address    = rd_q;
  assign add_source_immediate_value = imm_q;
  assign halted                     = halted_q;
  assign illegal_instr              = illegal_q;
  assign accept_timeout             = timeout_q;
  assign retired_count              = retired_q;

endmodule

// File: tb/tb_instruction_decode_controller.sv
// Self-checking bench: ROM + behavioural add controller, vector table and a
// scoreboard of expected dispatch fields checked on every add_start.
module tb_instruction_decode_controller;

  typedef struct packed {
    logic [4:0]  pc;
    logic [1:0]  ty;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] imm;
  } fields_t;

  typedef struct {
    string      name;
    logic [4:0] addr;
    logic [31:0] instr;
    logic [4:0] next_pc;
    bit         is_add;
    fields_t    f;
    logic [4:0] exp_pc;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic run = 1'b0;
  logic [4:0]  imem_addr;
  logic [31:0] imem_data;
  logic        add_start;
  logic [4:0]  add_pc;
  logic [1:0]  add_operation_type;
  logic [4:0]  add_source_1_address, add_source_2_address, add_destination_address;
  logic [31:0] add_source_immediate_value;
  logic        add_busy, add_done;
  logic [4:0]  add_next_pc;
  logic        halted, illegal_instr, accept_timeout;
  logic [15:0] retired_count;

  instruction_decode_controller #(
    .RESET_PC       (5'd0),
    .ACCEPT_TIMEOUT (4)
  ) dut (
    .clk                        (clk),
    .rst                        (rst),
    .run                        (run),
    .imem_addr                  (imem_addr),
    .imem_data                  (imem_data),
    .add_start                  (add_start),
    .add_pc                     (add_pc),
    .add_operation_type         (add_operation_type),
    .add_source_1_address       (add_source_1_address),
    .add_source_2_address       (add_source_2_address),
    .add_destination_address    (add_destination_address),
    .add_source_immediate_value (add_source_immediate_value),
    .add_busy                   (add_busy),
    .add_done                   (add_done),
    .add_next_pc                (add_next_pc),
    .halted                     (halted),
    .illegal_instr              (illegal_instr),
    .accept_timeout             (accept_timeout),
    .retired_count              (retired_count)
  );

  always #5 clk = ~clk;

  logic [31:0] rom [32];
  always @(posedge clk) imem_data <= rom[imem_addr];

  // Behavioural add controller: busy rises m_delay edges after start (1 = next
  // cycle), stays m_lat cycles, then done (sticky) with m_next_pc.
  int         m_delay = 1;
  int         m_lat = 2;
  bit         m_stale = 1'b0;
  bit         m_never = 1'b0;
  logic [4:0] m_next_pc = 5'd0;
  bit         m_active;
  int         m_k;
  int         k_now;
  assign k_now = add_start ? 0 : m_k;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      add_busy    <= 1'b0;
      add_done    <= 1'b0;
      add_next_pc <= 5'd0;
      m_active    <= 1'b0;
      m_k         <= 0;
    end else begin
      if (add_start) begin
        m_active <= 1'b1;
        m_k      <= 1;
        if (!m_stale) add_done <= 1'b0;
      end else if (m_active) begin
        m_k <= m_k + 1;
      end
      if ((add_start || m_active) && !m_never) begin
        if (k_now == m_delay - 1) begin
          add_busy <= 1'b1;
          add_done <= 1'b0;
        end
        if (k_now == m_delay - 1 + m_lat) begin
          add_busy    <= 1'b0;
          add_done    <= 1'b1;
          add_next_pc <= m_next_pc;
          m_active    <= 1'b0;
        end
      end
    end
  end

  int      checks = 0;
  int      failures = 0;
  int      exp_retired = 0;
  int      start_seen = 0;
  fields_t exp_q[$];
  fields_t last_f;
  bit      have_last = 1'b0;
  fields_t act_f;
  vec_t    vecs[7];

  assign act_f = {add_pc, add_operation_type, add_source_1_address, add_source_2_address,
                  add_destination_address, add_source_immediate_value};

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mk(input logic [5:0] op, input logic [4:0] rd,
                                     input logic [4:0] rs1, input logic [15:0] lo);
    return {op, rd, rs1, lo};
  endfunction

  function automatic vec_t mkv(input string n, input logic [4:0] a, input logic [31:0] ins,
                               input logic [4:0] np, input bit ia, input fields_t f,
                               input logic [4:0] ep);
    vec_t v;
    v.name = n; v.addr = a; v.instr = ins; v.next_pc = np;
    v.is_add = ia; v.f = f; v.exp_pc = ep;
    return v;
  endfunction

  // Scoreboard: every start pops one expected record; fields must hold while busy.
  always @(negedge clk) begin
    if (!rst && add_start) begin
      start_seen++;
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected add_start: got pc %0h expected no dispatch", add_pc);
      end else begin
        last_f = exp_q.pop_front();
        have_last = 1'b1;
        check("issue fields", 64'(act_f), 64'(last_f));
      end
    end else if (!rst && add_busy && have_last) begin
      check("fields held", 64'(act_f), 64'(last_f));
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    have_last = 1'b0;
    exp_q.delete();
    exp_retired = 0;
    @(negedge clk);
  endtask

  task automatic run_instr(input string name, input logic [4:0] addr,
                           input logic [4:0] exp_pc, input bit is_add);
    int s0;
    int n;
    s0 = start_seen;
    n = 0;
    check({name, " start pc"}, 64'(imem_addr), 64'(addr));
    run = 1'b1;
    @(posedge clk);
    #1 run = 1'b0;
    while (retired_count != 16'(exp_retired) && !halted && n < 40) begin
      @(negedge clk);
      n++;
    end
    check({name, " retired"}, 64'(retired_count), 64'(exp_retired));
    // FSM must park in IDLE: PC and count stay put while run is low
    repeat (3) @(negedge clk);
    check({name, " pc"}, 64'(imem_addr), 64'(exp_pc));
    check({name, " parked retired"}, 64'(retired_count), 64'(exp_retired));
    check({name, " halted"}, 64'(halted), 64'(0));
    check({name, " start count"}, 64'(start_seen - s0), 64'(is_add));
  endtask

  task automatic wait_halt();
    int n;
    n = 0;
    while (!halted && n < 20) begin
      @(negedge clk);
      n++;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int s0;
    int n;
    for (int i = 0; i < 32; i++) rom[i] = 32'h0;

    vecs[0] = mkv("add", 5'd0, mk(6'h01, 5'd3, 5'd1, {5'd2, 11'd0}), 5'd1, 1'b1,
                  {5'd0, 2'd0, 5'd1, 5'd2, 5'd3, 32'd0}, 5'd1);
    vecs[1] = mkv("addi", 5'd1, mk(6'h02, 5'd4, 5'd1, 16'h3F80), 5'd31, 1'b1,
                  {5'd1, 2'd1, 5'd1, 5'd0, 5'd4, 32'h3F80_0000}, 5'd31);
    vecs[2] = mkv("nop_wrap", 5'd31, 32'h03FF_FFFF, 5'd0, 1'b0, '0, 5'd0);
    vecs[3] = mkv("add_hi", 5'd0, mk(6'h01, 5'd31, 5'd30, {5'd29, 11'd0}), 5'd10, 1'b1,
                  {5'd0, 2'd0, 5'd30, 5'd29, 5'd31, 32'd0}, 5'd10);
    vecs[4] = mkv("addi_ffff", 5'd10, mk(6'h02, 5'd0, 5'd31, 16'hFFFF), 5'd11, 1'b1,
                  {5'd10, 2'd1, 5'd31, 5'd0, 5'd0, 32'hFFFF_0000}, 5'd11);
    vecs[5] = mkv("nop", 5'd11, 32'h0000_0000, 5'd0, 1'b0, '0, 5'd12);
    vecs[6] = mkv("add_jump", 5'd12, mk(6'h01, 5'd7, 5'd8, {5'd9, 11'd0}), 5'd20, 1'b1,
                  {5'd12, 2'd0, 5'd8, 5'd9, 5'd7, 32'd0}, 5'd20);

    repeat (2) @(negedge clk);
    check("reset imem_addr", 64'(imem_addr), 64'(0));
    check("reset add_start", 64'(add_start), 64'(0));
    check("reset add fields", 64'(act_f), 64'(0));
    check("reset halted", 64'(halted), 64'(0));
    check("reset illegal", 64'(illegal_instr), 64'(0));
    check("reset timeout", 64'(accept_timeout), 64'(0));
    check("reset retired", 64'(retired_count), 64'(0));
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 7; i++) begin
      rom[vecs[i].addr] = vecs[i].instr;
      m_next_pc = vecs[i].next_pc;
      if (vecs[i].is_add) exp_q.push_back(vecs[i].f);
      exp_retired++;
      run_instr(vecs[i].name, vecs[i].addr, vecs[i].exp_pc, vecs[i].is_add);
    end

    // Stale done from the previous op stays high; busy arrives late
    rom[20] = mk(6'h01, 5'd1, 5'd2, {5'd3, 11'd0});
    m_next_pc = 5'd5;
    m_stale = 1'b1;
    m_delay = 3;
    exp_q.push_back({5'd20, 2'd0, 5'd2, 5'd3, 5'd1, 32'd0});
    exp_retired++;
    run_instr("stale_done", 5'd20, 5'd5, 1'b1);
    m_stale = 1'b0;
    m_delay = 1;

    // HALT at pc 5
    rom[5] = {6'h3F, 26'h0};
    s0 = start_seen;
    run = 1'b1;
    wait_halt();
    repeat (4) @(negedge clk);
    check("halt halted", 64'(halted), 64'(1));
    check("halt illegal", 64'(illegal_instr), 64'(0));
    check("halt timeout", 64'(accept_timeout), 64'(0));
    check("halt pc", 64'(imem_addr), 64'(5));
    check("halt retired", 64'(retired_count), 64'(exp_retired));
    check("halt no start", 64'(start_seen - s0), 64'(0));
    run = 1'b0;

    // Illegal opcode
    do_reset();
    rom[0] = {6'h15, 26'h1234};
    run = 1'b1;
    wait_halt();
    @(negedge clk);
    run = 1'b0;
    check("illegal flag", 64'(illegal_instr), 64'(1));
    check("illegal halted", 64'(halted), 64'(1));
    check("illegal timeout", 64'(accept_timeout), 64'(0));
    check("illegal pc", 64'(imem_addr), 64'(0));
    check("illegal retired", 64'(retired_count), 64'(0));

    // Busy never arrives: timeout after four WAIT_ACCEPT cycles
    do_reset();
    m_never = 1'b1;
    rom[0] = mk(6'h01, 5'd3, 5'd1, {5'd2, 11'd0});
    exp_q.push_back({5'd0, 2'd0, 5'd1, 5'd2, 5'd3, 32'd0});
    run = 1'b1;
    @(posedge clk);
    #1 run = 1'b0;
    n = 0;
    while (!add_start && n < 10) begin
      @(negedge clk);
      n++;
    end
    check("timeout add_start seen", 64'(add_start), 64'(1));
    repeat (4) @(negedge clk);
    check("timeout not early", 64'(accept_timeout), 64'(0));
    check("halted not early", 64'(halted), 64'(0));
    @(negedge clk);
    check("timeout flag", 64'(accept_timeout), 64'(1));
    check("timeout halted", 64'(halted), 64'(1));
    check("timeout illegal", 64'(illegal_instr), 64'(0));
    check("timeout pc", 64'(imem_addr), 64'(0));
    check("timeout retired", 64'(retired_count), 64'(0));
    m_never = 1'b0;

    // Reset asserted while waiting for done
    do_reset();
    m_lat = 6;
    rom[0] = 32'h0;
    exp_retired = 1;
    run_instr("pre_rst_nop", 5'd0, 5'd1, 1'b0);
    rom[1] = mk(6'h01, 5'd9, 5'd10, {5'd11, 11'd0});
    m_next_pc = 5'd7;
    exp_q.push_back({5'd1, 2'd0, 5'd10, 5'd11, 5'd9, 32'd0});
    run = 1'b1;
    @(posedge clk);
    #1 run = 1'b0;
    n = 0;
    while (!add_busy && n < 12) begin
      @(negedge clk);
      n++;
    end
    check("rst test busy seen", 64'(add_busy), 64'(1));
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("async rst imem_addr", 64'(imem_addr), 64'(0));
    check("async rst add_start", 64'(add_start), 64'(0));
    check("async rst fields", 64'(act_f), 64'(0));
    check("async rst halted", 64'(halted), 64'(0));
    check("async rst retired", 64'(retired_count), 64'(0));
    @(negedge clk);
    rst = 1'b0;
    have_last = 1'b0;
    m_lat = 2;
    @(negedge clk);
    exp_retired = 1;
    run_instr("restart_nop", 5'd0, 5'd1, 1'b0);

    check("scoreboard drained", 64'(exp_q.size()), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
